// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encodings and
// helpers that derive the baud divider from the clock and bit rate.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter for the UART receiver. Counts clocks while enabled,
// restarts on clear, and flags the mid-start-bit and full-bit positions.
module uart_baud_cnt #(
    parameter int DIV  = 434,
    parameter int HALF = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Clock counter: cleared by the FSM on every state change or bit boundary
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_M1);
    assign full_tick = (cnt == DIV_M1);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver fed by the line edge detector. A falling-edge pulse
// starts a frame; the start bit is confirmed at mid-bit, then data (LSB
// first) and the stop bit are sampled one bit period apart.
// Optional even-parity bit enabled with the macro UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 neg_rx_int,
    input  logic                 rx_level,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int HALF = calc_half(CLK_FREQ, BAUD);
    localparam int IW   = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 half_tick;
    logic                 full_tick;
    logic                 cnt_clear;
    logic                 cnt_enable;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
`endif

    // The counter restarts whenever the FSM moves and at every bit boundary
    assign cnt_clear  = (state == ST_IDLE) || (state_nxt != state) || full_tick;
    assign cnt_enable = (state != ST_IDLE);

    uart_baud_cnt #(
        .DIV  (DIV),
        .HALF (HALF)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // Next-state decode; start edges are only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (neg_rx_int) state_nxt = ST_START;
            end
            ST_START: begin
                if (half_tick) state_nxt = rx_level ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (full_tick && (bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (full_tick) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and one-cycle strobes; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_START: begin
                    if (half_tick) bit_idx <= '0;
                end
                ST_DATA: begin
                    if (full_tick) begin
                        shift   <= {rx_level, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (full_tick) parity_bad <= (^shift) ^ rx_level;
                end
`endif
                ST_STOP: begin
                    if (full_tick) begin
                        if (rx_level) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err <= parity_bad;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame with default parameters
// (DIV=434, HALF=217). Works with or without UART_RX_PARITY_EN.
module tb_uart_rx_frame;

    localparam int DIV  = 434;
    localparam int HALF = 217;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int LATENCY = HALF + 9 * DIV + PAR_EN * DIV;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       flip_parity;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       neg_rx_int;
    logic       rx_level;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   cyc         = 0;
    int   checks      = 0;
    int   errors      = 0;
    int   valid_cnt   = 0;
    int   ferr_cnt    = 0;
    int   perr_cnt    = 0;
    int   overlap_cnt = 0;
    int   valid_cyc   = 0;
    int   start_cyc   = 0;
    logic last_perr   = 1'b0;

    vec_t tbl [0:5];

    uart_rx_frame #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (115200),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .neg_rx_int (neg_rx_int),
        .rx_level   (rx_level),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time strobes against start edges
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            last_perr = parity_err;
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (parity_err === 1'b1) perr_cnt = perr_cnt + 1;
        if (rx_valid === 1'b1 && frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Hold the line at one level for one bit period; entered/left at posedge+1
    task automatic drive_bit(input logic b);
        rx_level = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Full frame: start pulse plus start bit, data LSB first, parity, stop
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic flip);
        start_cyc  = cyc + 1;
        rx_level   = 1'b0;
        neg_rx_int = 1'b1;
        @(posedge clk);
        #1;
        neg_rx_int = 1'b0;
        repeat (DIV - 1) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (PAR_EN != 0) drive_bit((^data) ^ flip);
        drive_bit(stop_bit);
        rx_level = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        send_frame(v.data, v.stop_bit, v.flip_parity);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        int         v0;
        int         f0;
        int         p0;
        logic       exp_perr;
        logic [7:0] d77;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[1] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03};
        tbl[3] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

        rst        = 1'b1;
        neg_rx_int = 1'b0;
        rx_level   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset parity_err", parity_err, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rx_data", rx_data, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            p0 = perr_cnt;
            exp_perr = (PAR_EN != 0) && tbl[i].flip_parity;
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d rx_valid pulses", i), valid_cnt - v0, int'(tbl[i].exp_valid));
            checkOutput($sformatf("vec%0d frame_err pulses", i), ferr_cnt - f0, int'(tbl[i].exp_ferr));
            checkOutput($sformatf("vec%0d parity_err pulses", i), perr_cnt - p0, int'(exp_perr));
            checkOutput($sformatf("vec%0d rx_data", i), rx_data, tbl[i].exp_data);
            checkOutput($sformatf("vec%0d busy idle", i), busy, 0);
            if (tbl[i].exp_valid) begin
                checkOutput($sformatf("vec%0d latency", i), valid_cyc - start_cyc, LATENCY);
                checkOutput($sformatf("vec%0d parity_err at strobe", i), last_perr, int'(exp_perr));
            end
        end

        // False start: line returns high before the mid-start-bit sample
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx_level   = 1'b0;
        neg_rx_int = 1'b1;
        @(posedge clk);
        #1;
        neg_rx_int = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rx_level = 1'b1;
        repeat (117) @(posedge clk);
        #1;
        checkOutput("false start busy at 216", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("false start busy at 217", busy, 0);
        repeat (DIV) @(posedge clk);
        #1;
        checkOutput("false start rx_valid pulses", valid_cnt - v0, 0);
        checkOutput("false start frame_err pulses", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("after false start rx_valid pulses", valid_cnt - v0, 1);
        checkOutput("after false start rx_data", rx_data, 8'h3C);

        // Back-to-back: second start edge 217 clocks after first stop midpoint
        v0 = valid_cnt;
        send_frame(8'h01, 1'b1, 1'b0);
        checkOutput("b2b first rx_data", rx_data, 8'h01);
        checkOutput("b2b first pulses", valid_cnt - v0, 1);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("b2b total pulses", valid_cnt - v0, 2);
        checkOutput("b2b second rx_data", rx_data, 8'hFF);
        checkOutput("b2b second latency", valid_cyc - start_cyc, LATENCY);

        // Reset in the middle of data bit 4 of frame 0x77
        v0  = valid_cnt;
        f0  = ferr_cnt;
        d77 = 8'h77;
        rx_level   = 1'b0;
        neg_rx_int = 1'b1;
        @(posedge clk);
        #1;
        neg_rx_int = 1'b0;
        repeat (DIV - 1) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(d77[i]);
        rx_level = d77[4];
        repeat (HALF) @(posedge clk);
        #1;
        checkOutput("mid-frame busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset rx_valid", rx_valid, 0);
        checkOutput("mid reset frame_err", frame_err, 0);
        checkOutput("mid reset parity_err", parity_err, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset rx_data", rx_data, 0);
        rst      = 1'b0;
        rx_level = 1'b1;
        repeat (12 * DIV) @(posedge clk);
        #1;
        checkOutput("aborted frame rx_valid pulses", valid_cnt - v0, 0);
        checkOutput("aborted frame frame_err pulses", ferr_cnt - f0, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("post reset rx_valid pulses", valid_cnt - v0, 1);
        checkOutput("post reset rx_data", rx_data, 8'h12);
        checkOutput("post reset latency", valid_cyc - start_cyc, LATENCY);

        checkOutput("strobe overlap count", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial-frame receiver placed directly downstream of the line edge detector.
- Consumes the detector's falling-edge pulse as a start-bit hint, together with the synchronized line level.
- Times the frame with a baud counter, samples each bit at mid-bit, and delivers one byte per valid frame as a single-cycle strobe.
- Sits between the edge detector and the command/byte consumer.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate in bits/s.
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- neg_rx_int  input  1  one-cycle pulse: synchronized line fell 1->0.
- rx_level  input  1  synchronized line level (idle = 1).
- rx_data  output  DATA_BITS  last good received byte; held between frames.
- rx_valid  output  1  one-cycle strobe; rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled 0.
- parity_err  output  1  one-cycle strobe; parity mismatch (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface clocking: one clock; reset is synchronous and active-high.
- Constants:
  - DIV = CLK_FREQ/BAUD, integer division.
  - HALF = DIV/2.
  - Counter width = clog2(DIV).
  - Bit index width = clog2(DATA_BITS+1).
- Reset: state=IDLE; cnt=0; bit_idx=0; shift=0; rx_data=0; rx_valid=frame_err=parity_err=busy=0. Reset wins over every other event, including mid-frame; the partial frame is discarded with no strobe.
- IDLE:
  - cnt held at 0.
  - neg_rx_int=1 -> START with cnt=0.
  - neg_rx_int is ignored in every other state.
- START:
  - cnt increments each cycle.
  - At cnt==HALF-1, sample rx_level.
    - 1 -> false start (glitch): go to IDLE, no strobe.
    - 0 -> go to DATA with cnt=0, bit_idx=0.
- DATA:
  - At cnt==DIV-1: shift rx_level into the MSB of shift (LSB-first frame), cnt=0, bit_idx++.
  - When bit_idx reaches DATA_BITS-1 on a sample: go to STOP (or PARITY if enabled).
- STOP:
  - At cnt==DIV-1, sample rx_level and return to IDLE in the same transition. IDLE is re-entered at the stop-bit midpoint, so the next start edge is never missed.
  - Sample 1: rx_data<=shift, rx_valid=1 for exactly one cycle.
  - Sample 0: frame_err=1 for one cycle; rx_data unchanged; rx_valid=0.
- Latency: rx_valid is asserted exactly HALF + (DATA_BITS+1)*DIV clocks after the cycle in which neg_rx_int is high (+DIV with parity). With defaults this is 4123 clocks.
- Strobes never overlap: at most one of rx_valid/frame_err per frame. parity_err may coincide with rx_valid.
- busy is registered and equals (state != IDLE).
- Back-to-back frames: a start edge arriving during the second half of the stop bit is caught, because IDLE has already been re-entered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; one bit at cnt==DIV-1.
  - Even parity: XOR of data bits and parity bit must be 0.
  - On mismatch, parity_err pulses one cycle, coincident with the STOP-sample cycle. rx_data is still updated if the stop bit is good.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_err tied to 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - Helper function computing DIV/HALF from CLK_FREQ and BAUD.
- Sub-module uart_baud_cnt:
  - Inputs: clear, enable.
  - Outputs: half_tick (cnt==HALF-1) and full_tick (cnt==DIV-1).
  - Instantiated once; the FSM stays in the top.

Test Plan (defaults: DIV=434, HALF=217):
- Frame 0xA5, good stop -> rx_valid high one cycle, 4123 clocks after neg_rx_int; rx_data=0xA5; frame_err=0.
- neg_rx_int pulse with line back at 1 after 100 clocks -> no strobe; busy drops 217 clocks after the pulse; next frame 0x3C received correctly.
- Frame 0x5A with stop bit forced 0 -> frame_err one cycle; rx_valid=0; rx_data keeps the previous 0xA5.
- Two frames 0x01 then 0xFF, second start edge 217 clocks after first stop midpoint -> two rx_valid strobes, data 0x01 then 0xFF.
- rst asserted at bit 4 of frame 0x77 -> all outputs 0 the next cycle; no strobe; a following frame 0x12 received.
- With UART_RX_PARITY_EN, frame 0x03 + parity 1 -> parity_err=1 alongside rx_valid with rx_data=0x03. Same frame with parity 0 -> parity_err=0.
